// File: rtl/sreg_writeback.sv
// Register-file writeback stage: merges ALU results and formatted load data into a
// single registered write port. A small load queue sits in front of the arbiter.
module sreg_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [4:0]            alu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [4:0]            lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic [2:0]            lsu_funct3_i,
    input  logic [1:0]            lsu_byte_off_i,
    output logic                  reg_write_o,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  idle_o
);
    // Both inputs use valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; the sender keeps its payload stable until that edge.

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

    logic [4:0]            r_q_rd   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [LQ_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [1:0]            r_starve;
    logic                  r_wr;
    logic [4:0]            r_rd;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_q_empty;
    logic                  w_force_alu;
    logic                  w_alu_ready;
    logic                  w_lsu_ready;
    logic                  w_grant_alu;
    logic                  w_grant_q;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_fmt;
    logic [1:0]            w_starve_nxt;

    // Load formatting happens once at push so the queue only ever holds final values.
    always_comb begin
        w_shifted = lsu_data_i >> {lsu_byte_off_i, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = lsu_byte_off_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];
        case (lsu_funct3_i)
            3'b000:  w_fmt = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_fmt = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_fmt = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_fmt = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_fmt = lsu_data_i;
        endcase
    end

    assign w_q_empty   = (r_count == '0);
    assign w_force_alu = (r_starve == 2'd2);
    assign w_alu_ready = w_q_empty | w_force_alu;
    assign w_lsu_ready = (r_count != FULL_CNT);
    assign w_grant_alu = alu_valid_i & w_alu_ready;
    assign w_grant_q   = ~w_q_empty & ~w_grant_alu;
    assign w_push      = lsu_valid_i & w_lsu_ready;

    // Counts queue grants taken while the ALU was waiting; saturates at the force level.
    always_comb begin
        w_starve_nxt = r_starve;
        if (!alu_valid_i || w_grant_alu) begin
            w_starve_nxt = 2'd0;
        end else if (w_grant_q && !w_force_alu) begin
            w_starve_nxt = r_starve + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                r_q_rd[i]   <= '0;
                r_q_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_q_rd[r_wr_ptr]   <= lsu_rd_addr_i;
                r_q_data[r_wr_ptr] <= w_fmt;
                r_wr_ptr           <= r_wr_ptr + PW'(1);
            end
            if (w_grant_q) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_grant_q})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_starve <= w_starve_nxt;
        end
    end

    // Writes to x0 still move through the output register but never assert the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_grant_alu) begin
            r_wr   <= (alu_rd_addr_i != 5'd0);
            r_rd   <= alu_rd_addr_i;
            r_data <= alu_data_i;
        end else if (w_grant_q) begin
            r_wr   <= (r_q_rd[r_rd_ptr] != 5'd0);
            r_rd   <= r_q_rd[r_rd_ptr];
            r_data <= r_q_data[r_rd_ptr];
        end else begin
            r_wr   <= 1'b0;
        end
    end

    assign alu_ready_o = w_alu_ready;
    assign lsu_ready_o = w_lsu_ready;
    assign reg_write_o = r_wr;
    assign rd_addr_o   = r_rd;
    assign rd_data_o   = r_data;
    assign idle_o      = w_q_empty & ~r_wr;

endmodule

// File: tb/tb_sreg_writeback.sv
// Directed bench for sreg_writeback: latency, load formatting, arbitration fairness,
// x0 suppression and asynchronous reset behaviour, each checked against hand values.
module tb_sreg_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_data_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byte_off_i;
    logic        reg_write_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        idle_o;

    int n_vec = 0;
    int n_err = 0;

    sreg_writeback #(.DATA_WIDTH(32), .LQ_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_addr_i  (alu_rd_addr_i),
        .alu_data_i     (alu_data_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_funct3_i   (lsu_funct3_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .reg_write_o    (reg_write_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .idle_o         (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic wr, input logic [4:0] rd,
                           input logic [31:0] data);
        chk({tag, ".wr"}, 32'(reg_write_o), 32'(wr));
        chk({tag, ".rd"}, 32'(rd_addr_o), 32'(rd));
        chk({tag, ".data"}, rd_data_o, data);
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid_i   = 1'b1;
        alu_rd_addr_i = rd;
        alu_data_i    = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
        lsu_valid_i    = 1'b1;
        lsu_rd_addr_i  = rd;
        lsu_data_i     = data;
        lsu_funct3_i   = 3'b010;
        lsu_byte_off_i = 2'd0;
    endtask

    // Both sources busy from an idle start; ends with the load queue full (L2, L3)
    // and A1 sitting in the output register.
    task automatic contention_prefix();
        drive_alu(5'd10, 32'hA000_0000);
        drive_lsu(5'd20, 32'hB000_0000);
        chk("c0.alu_ready", 32'(alu_ready_o), 32'd1);
        chk("c0.lsu_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        chk_out("c1.A0", 1'b1, 5'd10, 32'hA000_0000);
        drive_alu(5'd11, 32'hA000_0001);
        drive_lsu(5'd21, 32'hB000_0001);
        chk("c1.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        chk_out("c2.L0", 1'b1, 5'd20, 32'hB000_0000);
        drive_lsu(5'd22, 32'hB000_0002);
        chk("c2.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        chk_out("c3.L1", 1'b1, 5'd21, 32'hB000_0001);
        chk("c3.alu_ready_forced", 32'(alu_ready_o), 32'd1);
        chk("c3.lsu_ready", 32'(lsu_ready_o), 32'd1);
        drive_lsu(5'd23, 32'hB000_0003);
        tick();
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t ext_tab[6];

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        ext_tab[0] = '{3'b000, 2'd3, 32'hFFFF_FF80};
        ext_tab[1] = '{3'b100, 2'd1, 32'h0000_007F};
        ext_tab[2] = '{3'b001, 2'd2, 32'hFFFF_80FF};
        ext_tab[3] = '{3'b101, 2'd0, 32'h0000_7F01};
        ext_tab[4] = '{3'b010, 2'd3, 32'h80FF_7F01};
        ext_tab[5] = '{3'b111, 2'd1, 32'h80FF_7F01};

        rst_n = 1'b0;
        alu_valid_i = 1'b0; alu_rd_addr_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_data_i = '0;
        lsu_funct3_i = '0;  lsu_byte_off_i = '0;

        // Reset values
        #3;
        chk_out("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.idle", 32'(idle_o), 32'd1);
        chk("reset.alu_ready", 32'(alu_ready_o), 32'd1);
        chk("reset.lsu_ready", 32'(lsu_ready_o), 32'd1);

        // Release reset and offer an ALU result for the very next edge
        @(negedge clk);
        rst_n = 1'b1;
        drive_alu(5'd5, 32'h1234_5678);
        tick();
        chk_out("alu_first", 1'b1, 5'd5, 32'h1234_5678);
        chk("alu_first.idle", 32'(idle_o), 32'd0);
        alu_valid_i = 1'b0;
        tick();
        chk_out("alu_hold", 1'b0, 5'd5, 32'h1234_5678);
        chk("alu_hold.idle", 32'(idle_o), 32'd1);

        // Load formatting and two-cycle load latency
        foreach (ext_tab[k]) begin
            lsu_valid_i    = 1'b1;
            lsu_rd_addr_i  = 5'd7;
            lsu_data_i     = 32'h80FF_7F01;
            lsu_funct3_i   = ext_tab[k].f3;
            lsu_byte_off_i = ext_tab[k].off;
            chk($sformatf("ext%0d.lsu_ready", k), 32'(lsu_ready_o), 32'd1);
            tick();
            lsu_valid_i = 1'b0;
            chk($sformatf("ext%0d.n1_wr", k), 32'(reg_write_o), 32'd0);
            chk($sformatf("ext%0d.n1_idle", k), 32'(idle_o), 32'd0);
            tick();
            chk_out($sformatf("ext%0d", k), 1'b1, 5'd7, ext_tab[k].exp);
            tick();
        end

        // Destination x0 consumes the slot without a write
        drive_alu(5'd0, 32'hDEAD_BEEF);
        tick();
        chk_out("rd0", 1'b0, 5'd0, 32'hDEAD_BEEF);
        chk("rd0.idle", 32'(idle_o), 32'd1);
        drive_alu(5'd1, 32'h0000_0042);
        tick();
        chk_out("rd1", 1'b1, 5'd1, 32'h0000_0042);
        alu_valid_i = 1'b0;
        tick();

        // Contention with a full queue: load, load, then ALU
        contention_prefix();
        chk_out("c4.A1", 1'b1, 5'd11, 32'hA000_0001);
        chk("c4.lsu_ready_full", 32'(lsu_ready_o), 32'd0);
        chk("c4.alu_ready", 32'(alu_ready_o), 32'd0);
        lsu_valid_i = 1'b0;
        drive_alu(5'd12, 32'hA000_0002);
        tick();
        chk_out("c5.L2", 1'b1, 5'd22, 32'hB000_0002);
        chk("c5.lsu_ready", 32'(lsu_ready_o), 32'd1);
        chk("c5.alu_ready", 32'(alu_ready_o), 32'd0);
        tick();
        chk_out("c6.L3", 1'b1, 5'd23, 32'hB000_0003);
        chk("c6.alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        chk_out("c7.A2", 1'b1, 5'd12, 32'hA000_0002);
        alu_valid_i = 1'b0;
        tick();
        chk_out("c8.quiet", 1'b0, 5'd12, 32'hA000_0002);
        chk("c8.idle", 32'(idle_o), 32'd1);

        // Mid-operation reset with two loads queued and a write pending
        contention_prefix();
        chk("rst_pre.wr", 32'(reg_write_o), 32'd1);
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 5'd0, 32'h0);
        chk("rst_mid.idle", 32'(idle_o), 32'd1);
        chk("rst_mid.lsu_ready", 32'(lsu_ready_o), 32'd1);
        chk("rst_mid.alu_ready", 32'(alu_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("rst_post%0d", i), 1'b0, 5'd0, 32'h0);
            chk($sformatf("rst_post%0d.idle", i), 32'(idle_o), 32'd1);
        end

        // Normal operation resumes after reset
        drive_alu(5'd3, 32'h0000_0055);
        tick();
        chk_out("post_rst_alu", 1'b1, 5'd3, 32'h0000_0055);
        alu_valid_i = 1'b0;
        tick();
        chk("post_rst_quiet.wr", 32'(reg_write_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sreg_writeback.md
SREG_WRITEBACK -- requirements
Module: sreg_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width; only 32 supported.
REQ-002 SHALL have parameter LQ_DEPTH, default 2, meaning load-result queue entries; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  ALU result present.
REQ-006 SHALL have port alu_ready_o  output  1  ALU result accepted this cycle when high with alu_valid_i.
REQ-007 SHALL have port alu_rd_addr_i  input  5  ALU destination register.
REQ-008 SHALL have port alu_data_i  input  DATA_WIDTH  ALU result.
REQ-009 SHALL have port lsu_valid_i  input  1  raw load word present.
REQ-010 SHALL have port lsu_ready_o  output  1  load queue can accept.
REQ-011 SHALL have port lsu_rd_addr_i  input  5  load destination register.
REQ-012 SHALL have port lsu_data_i  input  DATA_WIDTH  aligned memory word, little-endian.
REQ-013 SHALL have port lsu_funct3_i  input  3  load type (LB/LH/LW/LBU/LHU encodings).
REQ-014 SHALL have port lsu_byte_off_i  input  2  byte address offset.
REQ-015 SHALL have port reg_write_o  output  1  register-file write enable.
REQ-016 SHALL have port rd_addr_o  output  5  register-file write address.
REQ-017 SHALL have port rd_data_o  output  DATA_WIDTH  register-file write data.
REQ-018 SHALL have port idle_o  output  1  queue empty and no write in output register.

Function
REQ-019 Handshake: transfer on valid&ready at rising edge; valid-side payload held stable until accepted.
REQ-020 lsu_ready_o SHALL equal queue-not-full; no same-cycle bypass into a full queue even if popping.
REQ-021 Load formatting at push: 000 LB sign-extend byte[off]; 100 LBU zero-extend byte[off]; 001 LH sign-extend half[off[1]]; 101 LHU zero-extend half[off[1]]; 010 and all other codes pass word unchanged, offset ignored.
REQ-022 Arbiter grants at most one source per cycle; queue head has priority over ALU.
REQ-023 Starvation counter: after 2 consecutive queue grants with alu_valid_i high, next cycle SHALL grant ALU; counter clears on any ALU grant or when alu_valid_i is low.
REQ-024 alu_ready_o SHALL be high when queue empty or starvation rule forces ALU grant; combinational from state only, not from alu_valid_i.
REQ-025 Output registered: granted entry appears on rd_addr_o/rd_data_o with reg_write_o=1 on the following cycle, held one cycle.
REQ-026 Latency: ALU accept edge N -> reg_write_o high cycle N+1; load push edge N into empty queue -> reg_write_o high cycle N+2.
REQ-027 Granted entries with rd=0 SHALL be consumed with reg_write_o=0; rd_addr_o/rd_data_o still updated.
REQ-028 Cycles with no grant: reg_write_o=0, rd_addr_o/rd_data_o hold last value.
REQ-029 Queue pointers wrap modulo LQ_DEPTH; simultaneous push and pop when not full keeps count unchanged.
REQ-030 Loads retire in arrival order; ALU results retire in arrival order; no relative ordering guarantee between sources.
REQ-031 idle_o = queue empty and reg_write_o low.

Reset
REQ-032 On rst_n low, immediately: reg_write_o=0, rd_addr_o=0, rd_data_o=0, queue empty, pointers and starvation counter 0, lsu_ready_o=1, alu_ready_o=1, idle_o=1.
REQ-033 Reset mid-operation SHALL discard queued loads and any pending write; no write pulse after deassertion without new input.
REQ-034 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 ALU only: alu rd=5 data=0x1234_5678 accepted edge N -> cycle N+1 reg_write_o=1, rd_addr_o=5, rd_data_o=0x1234_5678.
REQ-036 Extension: data=0x80FF_7F01, rd=7: LB off=3 -> 0xFFFF_FF80; LBU off=1 -> 0x0000_007F; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01.
REQ-037 Contention: LQ_DEPTH=2, queue full, alu_valid_i held -> grant order load, load, ALU; lsu_ready_o low while full; no write lost or duplicated.
REQ-038 rd=0: ALU rd=0 data=0xDEAD_BEEF accepted -> reg_write_o stays 0, next ALU rd=1 written normally.
REQ-039 Reset: 2 loads queued, rst_n pulsed low mid-cycle -> outputs zero immediately, idle_o=1, no write pulse for 3 cycles after release with inputs idle.
